// File: rtl/clkgen_pkg.sv
// Shared constants for the CPU phase/reset generator: phase width and
// per-phase decode masks (bit n of a mask is the level at ph == n).
package clkgen_pkg;
  localparam int               PH_W      = 3;
  localparam logic [PH_W-1:0]  PH_LAST   = 3'd7;
  localparam logic [7:0]       CLK1_MASK = 8'h0F;
  localparam logic [7:0]       CLK4_MASK = 8'h3C;
  localparam logic [7:0]       CLK6_MASK = 8'hC3;
  localparam logic [7:0]       CLK8_MASK = 8'h1E;
endpackage

// File: rtl/clkgen_stable_cnt.sv
// Saturating event counter with synchronous clear; o_done is a flop that
// rises on the same edge the count reaches MAX and holds until cleared.
module clkgen_stable_cnt #(
  parameter int MAX = 1024,
  parameter int W   = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] LAST_V = W'(MAX - 1);

  logic [W-1:0] r_cnt;
  logic         r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_en) begin
      if (r_cnt != MAX_V) r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_V) r_done <= 1'b1;
    end
  end

  assign o_done = r_done;
endmodule

// File: rtl/clkgen_phase_reset.sv
// Master-clock phase sequencer with oscillator settle timer and synchronous
// CPU reset release; stops/starts only on M-cycle (ph == 0) boundaries.
module clkgen_phase_reset
  import clkgen_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int STABLE_W      = 11,
  parameter int RESET_MCYCLES = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            OSC_ENA,
  input  logic            CLK_ENA,
  output logic            OSC_STABLE,
  output logic            SYNC_RESET,
  output logic            CLK1,
  output logic            CLK2,
  output logic            CLK4,
  output logic            nCLK4,
  output logic            CLK6,
  output logic            CLK8,
  output logic            CLK9,
  output logic [PH_W-1:0] PHASE,
  output logic            MCYC_STB
);
  localparam int MC_W = $clog2(RESET_MCYCLES + 1);

  logic            r_rs1, r_rs2;
  logic [PH_W-1:0] r_ph;
  logic            r_clk1, r_clk4, r_clk6, r_clk8, r_mcyc;
  logic [PH_W-1:0] w_ph_next;
  logic            w_osc_stable, w_osc_clr, w_mc_done, w_run;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rs1 <= 1'b1;
      r_rs2 <= 1'b1;
    end else begin
      r_rs1 <= 1'b0;
      r_rs2 <= r_rs1;
    end
  end

  assign w_osc_clr = ~OSC_ENA;

  clkgen_stable_cnt #(.MAX(STABLE_CYCLES), .W(STABLE_W)) u_osc_cnt (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_clr  (w_osc_clr),
    .i_en   (1'b1),
    .o_done (w_osc_stable)
  );

  // Counts completed M-cycles once the synchronized reset has dropped.
  clkgen_stable_cnt #(.MAX(RESET_MCYCLES), .W(MC_W)) u_mcyc_cnt (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_clr  (r_rs2),
    .i_en   (r_mcyc),
    .o_done (w_mc_done)
  );

  assign w_run     = OSC_ENA & w_osc_stable & (CLK_ENA | ~w_mc_done);
  assign w_ph_next = (r_ph != '0 || w_run) ? r_ph + 1'b1 : '0;

  // Phase levels are decoded from the next phase so they line up with r_ph.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ph   <= '0;
      r_clk1 <= CLK1_MASK[0];
      r_clk4 <= CLK4_MASK[0];
      r_clk6 <= CLK6_MASK[0];
      r_clk8 <= CLK8_MASK[0];
      r_mcyc <= 1'b0;
    end else begin
      r_ph   <= w_ph_next;
      r_clk1 <= CLK1_MASK[w_ph_next];
      r_clk4 <= CLK4_MASK[w_ph_next];
      r_clk6 <= CLK6_MASK[w_ph_next];
      r_clk8 <= CLK8_MASK[w_ph_next];
      r_mcyc <= (w_ph_next == PH_LAST);
    end
  end

  assign OSC_STABLE = w_osc_stable;
  assign SYNC_RESET = ~w_mc_done;
  assign CLK1       = r_clk1;
  assign CLK2       = ~r_clk1;
  assign CLK4       = r_clk4;
  assign nCLK4      = ~r_clk4;
  assign CLK6       = r_clk6;
  assign CLK8       = r_clk8;
  assign CLK9       = ~r_clk8;
  assign PHASE      = r_ph;
  assign MCYC_STB   = r_mcyc;
endmodule

// File: tb/tb_clkgen_phase_reset.sv
// Directed bench for clkgen_phase_reset with STABLE_CYCLES=8, RESET_MCYCLES=2.
module tb_clkgen_phase_reset;
  logic       CLK = 1'b0;
  logic       RESET, OSC_ENA, CLK_ENA;
  logic       OSC_STABLE, SYNC_RESET, CLK1, CLK2, CLK4, nCLK4, CLK6, CLK8, CLK9, MCYC_STB;
  logic [2:0] PHASE;
  int         errors = 0;
  int         checks = 0;

  clkgen_phase_reset #(.STABLE_CYCLES(8), .STABLE_W(4), .RESET_MCYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .OSC_ENA(OSC_ENA), .CLK_ENA(CLK_ENA),
    .OSC_STABLE(OSC_STABLE), .SYNC_RESET(SYNC_RESET),
    .CLK1(CLK1), .CLK2(CLK2), .CLK4(CLK4), .nCLK4(nCLK4), .CLK6(CLK6),
    .CLK8(CLK8), .CLK9(CLK9), .PHASE(PHASE), .MCYC_STB(MCYC_STB)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Edge i counted from the first edge after RESET (or OSC_ENA) goes low:
  // stable at edge 8, ph=1 at edge 9, reset released on the 7->0 at edge 24.
  task automatic release_seq();
    for (int i = 1; i <= 26; i++) begin
      tick();
      chk("rel_stable", 8'(OSC_STABLE), 8'(i >= 8));
      chk("rel_ph",     8'(PHASE),      8'((i < 9 || i > 24) ? 0 : (i - 8) % 8));
      chk("rel_sync",   8'(SYNC_RESET), 8'(i < 24));
    end
  endtask

  initial begin
    logic [15:0] p_clk1, p_clk4, p_clk6, p_clk8, p_stb;
    int          halt_ph [7];
    p_clk1 = 16'b1111000011110000;
    p_clk4 = 16'b0011110000111100;
    p_clk6 = 16'b1100001111000011;
    p_clk8 = 16'b0111100001111000;
    p_stb  = 16'b0000000100000001;
    halt_ph = '{4, 5, 6, 7, 0, 0, 0};

    // Power-on
    RESET = 1'b1; OSC_ENA = 1'b1; CLK_ENA = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("por_sync",   8'(SYNC_RESET), 8'd1);
    chk("por_clk1",   8'(CLK1),       8'd1);
    chk("por_clk2",   8'(CLK2),       8'd0);
    chk("por_nclk4",  8'(nCLK4),      8'd1);
    chk("por_clk9",   8'(CLK9),       8'd1);
    chk("por_clk6",   8'(CLK6),       8'd1);
    chk("por_stb",    8'(MCYC_STB),   8'd0);
    chk("por_ph",     8'(PHASE),      8'd0);
    chk("por_stable", 8'(OSC_STABLE), 8'd0);
    RESET = 1'b0;
    release_seq();

    // Free run, starting from ph=0
    CLK_ENA = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("run_ph",    8'(PHASE),    8'(k % 8));
      chk("run_clk1",  8'(CLK1),     8'(p_clk1[15-k]));
      chk("run_clk2",  8'(CLK2),     8'(!p_clk1[15-k]));
      chk("run_clk4",  8'(CLK4),     8'(p_clk4[15-k]));
      chk("run_nclk4", 8'(nCLK4),    8'(!p_clk4[15-k]));
      chk("run_clk6",  8'(CLK6),     8'(p_clk6[15-k]));
      chk("run_clk8",  8'(CLK8),     8'(p_clk8[15-k]));
      chk("run_clk9",  8'(CLK9),     8'(!p_clk8[15-k]));
      chk("run_stb",   8'(MCYC_STB), 8'(p_stb[15-k]));
      tick();
    end

    // HALT at ph=3
    for (int i = 0; i < 3; i++) tick();
    chk("halt_start", 8'(PHASE), 8'd3);
    CLK_ENA = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("halt_ph", 8'(PHASE), 8'(halt_ph[i]));
    end
    CLK_ENA = 1'b1;
    tick();
    chk("halt_wake", 8'(PHASE), 8'd1);

    // STOP at ph=5, then wake
    for (int i = 0; i < 4; i++) tick();
    chk("stop_start", 8'(PHASE), 8'd5);
    OSC_ENA = 1'b0;
    tick();
    chk("stop_stable", 8'(OSC_STABLE), 8'd0);
    chk("stop_ph6",    8'(PHASE),      8'd6);
    tick();
    chk("stop_ph7",    8'(PHASE),      8'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stop_hold", 8'(PHASE), 8'd0);
    end
    OSC_ENA = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("wake_stable", 8'(OSC_STABLE), 8'(i >= 8));
      chk("wake_ph",     8'(PHASE),      8'(i == 9 ? 1 : 0));
      chk("wake_sync",   8'(SYNC_RESET), 8'd0);
    end

    // RESET pulse mid-cycle at ph=4, CLK_ENA held low afterwards
    for (int i = 0; i < 3; i++) tick();
    chk("mid_start", 8'(PHASE), 8'd4);
    CLK_ENA = 1'b0;
    RESET   = 1'b1;
    #1;
    chk("mid_ph",     8'(PHASE),      8'd0);
    chk("mid_sync",   8'(SYNC_RESET), 8'd1);
    chk("mid_stable", 8'(OSC_STABLE), 8'd0);
    chk("mid_clk1",   8'(CLK1),       8'd1);
    chk("mid_clk8",   8'(CLK8),       8'd0);
    tick();
    RESET = 1'b0;
    release_seq();

    // RESET while stopped: nothing moves until the oscillator comes back
    OSC_ENA = 1'b0;
    RESET   = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stop_rst_sync",   8'(SYNC_RESET), 8'd1);
      chk("stop_rst_ph",     8'(PHASE),      8'd0);
      chk("stop_rst_stable", 8'(OSC_STABLE), 8'd0);
    end
    OSC_ENA = 1'b1;
    release_seq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
